// File: rtl/mac_pe_dbuf.sv
// Weight-stationary systolic MAC processing element with a double-buffered weight,
// valid-tagged dataflow and optional saturating accumulation with a sticky overflow flag.
module mac_pe_dbuf #(
  parameter int unsigned A_W   = 4,
  parameter int unsigned W_W   = 8,
  parameter int unsigned ACC_W = 16,
  parameter bit          SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             w_load,
  input  logic [W_W-1:0]   w_in,
  output logic [W_W-1:0]   w_out,
  input  logic             w_swap,
  input  logic             in_valid,
  input  logic [A_W-1:0]   in_a,
  output logic             out_valid,
  output logic [A_W-1:0]   out_a,
  input  logic [ACC_W-1:0] in_sum,
  output logic [ACC_W-1:0] out_sum,
  input  logic             sat_clr,
  output logic             sat_flag
);

  localparam int unsigned P_W    = A_W + W_W;
  localparam int unsigned FULL_W = ACC_W + 1;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [W_W-1:0]    shadow_w;
  logic signed [W_W-1:0]    active_w;
  logic signed [P_W-1:0]    prod_c;
  logic signed [FULL_W-1:0] full_c;
  logic                     ovf_c;
  logic [ACC_W-1:0]         sum_c;

  // Shadow weight is forwarded straight down the load chain.
  assign w_out = shadow_w;

  // Full-precision signed product and sum; one guard bit detects overflow.
  assign prod_c = $signed(in_a) * active_w;
  assign full_c = FULL_W'($signed(in_sum)) + FULL_W'(prod_c);
  assign ovf_c  = full_c[ACC_W] ^ full_c[ACC_W-1];

  always_comb begin
    sum_c = full_c[ACC_W-1:0];
    if (SAT && ovf_c) begin
      sum_c = full_c[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_w  <= '0;
      active_w  <= '0;
      out_a     <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      sat_flag  <= 1'b0;
    end else begin
      if (w_load) shadow_w <= $signed(w_in);
      // Swap captures the pre-edge shadow, so load+swap in one cycle is safe.
      if (w_swap) active_w <= shadow_w;
      out_a     <= in_a;
      out_valid <= in_valid;
      out_sum   <= in_valid ? sum_c : in_sum;
      if (in_valid && ovf_c) begin
        sat_flag <= 1'b1;
      end else if (sat_clr) begin
        sat_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_pe_dbuf.sv
// Directed bench for mac_pe_dbuf: one saturating and one wrapping instance share stimulus.
module tb_mac_pe_dbuf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        w_load;
  logic [7:0]  w_in;
  logic        w_swap;
  logic        in_valid;
  logic [3:0]  in_a;
  logic [15:0] in_sum;
  logic        sat_clr;

  logic [7:0]  s_w_out,     w_w_out;
  logic        s_out_valid, w_out_valid;
  logic [3:0]  s_out_a,     w_out_a;
  logic [15:0] s_out_sum,   w_out_sum;
  logic        s_sat_flag,  w_sat_flag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_pe_dbuf #(.A_W(4), .W_W(8), .ACC_W(16), .SAT(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .w_load(w_load), .w_in(w_in), .w_out(s_w_out),
    .w_swap(w_swap), .in_valid(in_valid), .in_a(in_a), .out_valid(s_out_valid),
    .out_a(s_out_a), .in_sum(in_sum), .out_sum(s_out_sum), .sat_clr(sat_clr),
    .sat_flag(s_sat_flag)
  );

  mac_pe_dbuf #(.A_W(4), .W_W(8), .ACC_W(16), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .w_load(w_load), .w_in(w_in), .w_out(w_w_out),
    .w_swap(w_swap), .in_valid(in_valid), .in_a(in_a), .out_valid(w_out_valid),
    .out_a(w_out_a), .in_sum(in_sum), .out_sum(w_out_sum), .sat_clr(sat_clr),
    .sat_flag(w_sat_flag)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; w_load = 1'b0; w_in = '0; w_swap = 1'b0;
    in_valid = 1'b0; in_a = '0; in_sum = '0; sat_clr = 1'b0;
    tick();
    chk("rst0_w_out",  16'(s_w_out), 16'h0000);
    chk("rst0_sum",    s_out_sum, 16'h0000);
    chk("rst0_valid",  16'(s_out_valid), 16'h0000);
    chk("rst0_flag",   16'(s_sat_flag), 16'h0000);

    // Build nonzero state: weight 0x55 loaded and made active
    rst_n = 1'b1; w_load = 1'b1; w_in = 8'h55;
    tick();
    chk("pre_w_out", 16'(s_w_out), 16'h0055);
    w_load = 1'b0; w_swap = 1'b1; in_valid = 1'b1; in_a = 4'h3; in_sum = 16'h0010;
    tick();
    chk("pre_sum_old_w", s_out_sum, 16'h0010);
    w_swap = 1'b0;

    // Reset pulse between edges has no effect
    rst_n = 1'b0; #1; rst_n = 1'b1; #1;
    chk("glitch_w_out", 16'(s_w_out), 16'h0055);
    chk("glitch_sum",   s_out_sum, 16'h0010);
    chk("glitch_a",     16'(s_out_a), 16'h0003);

    rst_n = 1'b0;
    tick();
    chk("rst_w_out", 16'(s_w_out), 16'h0000);
    chk("rst_sum",   s_out_sum, 16'h0000);
    chk("rst_a",     16'(s_out_a), 16'h0000);
    chk("rst_valid", 16'(s_out_valid), 16'h0000);
    rst_n = 1'b1; in_a = 4'h5; in_sum = 16'h0007;
    tick();
    chk("post_rst_weight0", s_out_sum, 16'h0007);

    // Load and swap 0x7F
    in_valid = 1'b0; w_load = 1'b1; w_in = 8'h7F;
    tick();
    chk("load_w_out", 16'(s_w_out), 16'h007F);
    w_load = 1'b0; w_swap = 1'b1;
    tick();
    w_swap = 1'b0; in_valid = 1'b1; in_a = 4'hD; in_sum = 16'd100;
    tick();
    chk("mac_sum",   s_out_sum, 16'hFEE7);
    chk("mac_sum_w", w_out_sum, 16'hFEE7);
    chk("mac_flag",  16'(s_sat_flag), 16'h0000);
    chk("mac_a",     16'(s_out_a), 16'h000D);
    chk("mac_valid", 16'(s_out_valid), 16'h0001);

    // Positive and negative overflow
    in_a = 4'h7; in_sum = 16'd32700;
    tick();
    chk("sat_pos_sum",   s_out_sum, 16'h7FFF);
    chk("sat_pos_flag",  16'(s_sat_flag), 16'h0001);
    chk("wrap_pos_sum",  w_out_sum, 16'h8335);
    chk("wrap_pos_flag", 16'(w_sat_flag), 16'h0001);
    in_a = 4'h8; in_sum = 16'h8044;
    tick();
    chk("sat_neg_sum",  s_out_sum, 16'h8000);
    chk("wrap_neg_sum", w_out_sum, 16'h7C4C);

    // Set beats clear; then clear with no overflow
    sat_clr = 1'b1;
    tick();
    chk("set_wins_flag", 16'(s_sat_flag), 16'h0001);
    in_a = 4'h0; in_sum = 16'h0000;
    tick();
    chk("clr_flag",   16'(s_sat_flag), 16'h0000);
    chk("clr_flag_w", 16'(w_sat_flag), 16'h0000);
    sat_clr = 1'b0;

    // Bubble keeps sum and flag
    in_a = 4'h7; in_sum = 16'd32700;
    tick();
    chk("reset_flag_again", 16'(s_sat_flag), 16'h0001);
    in_valid = 1'b0; in_sum = 16'h1234;
    tick();
    chk("bubble_sum",   s_out_sum, 16'h1234);
    chk("bubble_valid", 16'(s_out_valid), 16'h0000);
    chk("bubble_flag",  16'(s_sat_flag), 16'h0001);
    chk("bubble_a",     16'(s_out_a), 16'h0007);
    sat_clr = 1'b1; in_sum = 16'h7FFF;
    tick();
    chk("bubble_no_mul", s_out_sum, 16'h7FFF);
    chk("bubble_no_set", 16'(s_sat_flag), 16'h0000);
    sat_clr = 1'b0;

    // Full-width weight -128
    w_load = 1'b1; w_in = 8'h80;
    tick();
    w_load = 1'b0; w_swap = 1'b1;
    tick();
    w_swap = 1'b0; in_valid = 1'b1; in_a = 4'h8; in_sum = 16'h0000;
    tick();
    chk("fullw_sum",  s_out_sum, 16'h0400);
    chk("fullw_flag", 16'(s_sat_flag), 16'h0000);

    // Same-cycle swap and load: active 2, shadow 5
    in_valid = 1'b0; w_load = 1'b1; w_in = 8'h02;
    tick();
    w_load = 1'b0; w_swap = 1'b1;
    tick();
    w_swap = 1'b0; w_load = 1'b1; w_in = 8'h05;
    tick();
    w_swap = 1'b1; w_load = 1'b1; w_in = 8'h09; in_valid = 1'b1; in_a = 4'h1; in_sum = 16'h0000;
    tick();
    chk("swapld_sum_old", s_out_sum, 16'h0002);
    chk("swapld_w_out",   16'(s_w_out), 16'h0009);
    w_swap = 1'b0; w_load = 1'b0;
    tick();
    chk("swapld_sum_new", s_out_sum, 16'h0005);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_pe_dbuf.md
# mac_pe_dbuf

Parametrised systolic multiply-accumulate processing element, the successor to the fixed 4-bit/8-bit/16-bit PE used in the weight-stationary array. It multiplies a horizontally streamed activation by a locally held weight and adds the product to a vertically streamed partial sum. Additions over the previous generation:
- Double-buffered weights: a shadow register is loaded through a dedicated daisy chain while the active weight keeps computing.
- Valid tagging, so bubbles flow through the array.
- Optional saturating accumulation with a sticky overflow flag.
- The full weight width is used in the multiply.

## Interface
- A_W, default 4: activation width, signed two's complement.
- W_W, default 8: weight width, signed two's complement.
- ACC_W, default 16: partial-sum width, signed; must be ≥ A_W+W_W.
- SAT, default 1: 1 = saturate accumulation to the ACC_W range; 0 = two's-complement wrap.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- w_load  in  1  shift enable for the weight chain.
- w_in  in  W_W  weight from the upstream PE, or the array edge.
- w_out  out  W_W  shadow weight forwarded to the downstream PE.
- w_swap  in  1  copy shadow weight into active weight.
- in_valid  in  1  activation/partial-sum valid.
- in_a  in  A_W  activation from the west neighbour.
- out_valid  out  1  registered in_valid.
- out_a  out  A_W  registered activation to the east neighbour.
- in_sum  in  ACC_W  partial sum from the north neighbour.
- out_sum  out  ACC_W  partial sum to the south neighbour.
- sat_clr  in  1  clears sat_flag.
- sat_flag  out  1  sticky: a saturation or wrap event occurred.

## Operation
- Registers: shadow_w, active_w (W_W), out_a, out_sum, out_valid, sat_flag.
- Weight chain:
  - w_load=1 → shadow_w ← w_in.
  - w_out is driven directly from shadow_w, so N chained PEs fill in N cycles.
  - w_load=0 → shadow_w holds.
- Swap:
  - w_swap=1 → active_w ← shadow_w (its pre-edge value).
  - w_load and w_swap in the same cycle: active_w gets the old shadow_w and shadow_w gets w_in.
- Compute, every cycle:
  - out_a ← in_a; out_valid ← in_valid. Compute is independent of the weight-chain controls.
  - in_valid=1: full = sext(in_sum) + sext(in_a × active_w), evaluated at ACC_W+1 bits. The product is signed (A_W+W_W bits) and uses all W_W weight bits.
    - SAT=1: clamp full to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
    - SAT=0: keep the low ACC_W bits.
    - Either mode: out_sum ← the resulting value.
  - in_valid=0 (bubble): out_sum ← in_sum unchanged; no multiply; sat_flag not updated.
- sat_flag:
  - Set when in_valid=1 and full lies outside the ACC_W signed range, in either SAT mode.
  - sat_clr=1 clears it.
  - Set and clear in the same cycle: set wins.
- The MAC in a given cycle uses the pre-edge active_w. A swap in cycle t affects results from cycle t+1 onward.

## Timing
- Reset: rst_n sampled low at a rising edge sets every register to 0. That covers shadow_w, active_w, w_out, out_a, out_sum, out_valid and sat_flag. Reset has priority over all other inputs.
- Reset asserted between edges has no effect until the next edge.
- Reset mid-load or mid-compute discards all weights and in-flight data. After release the PE computes with weight 0 until a new load and swap.
- Latency:
  - in_a, in_sum, in_valid → out_a, out_sum, out_valid: 1 cycle.
  - w_in → w_out: 1 cycle.
  - w_swap → first result using the new weight: the out_sum registered on the edge after the swap edge.
- No backpressure. The array controller guarantees inputs every cycle.

## Test plan
All scenarios use default parameters.
- Reset: drive nonzero state, then rst_n=0 for one edge → all outputs 0. Toggle rst_n low then high between edges → no change.
- Load and swap: w_load with w_in=0x7F; then w_swap; then in_valid=1, in_a=4'hD (−3), in_sum=100 → out_sum=0xFEE7 (−281) one cycle later, sat_flag=0.
- Full-width weight: weight −128 (0x80), in_a=−8, in_sum=0 → out_sum=1024. This catches use of only the low 4 weight bits.
- Saturation, weight 127:
  - SAT=1: in_sum=32700, in_a=7 → out_sum=32767, sat_flag=1. in_sum=−32700, in_a=−8 → out_sum=−32768.
  - SAT=0: the first case → out_sum=−31947, sat_flag=1.
  - sat_clr=1 for one cycle with no new overflow → sat_flag=0.
- Swap and load in the same cycle: active weight 2, shadow 5. w_swap=1, w_load=1, w_in=9, in_a=1, in_sum=0 → out_sum=2 that cycle and 5 the next; w_out=9.
- Bubble: in_valid=0, in_sum=0x1234, in_a=7 → out_sum=0x1234, out_valid=0, sat_flag unchanged.
